// File: rtl/fifo_rd_packer_if.sv
// Narrow read stream in, packed wide stream out, bundled for the FIFO read-side packer.
interface fifo_rd_packer_if #(
    parameter int P_WIDTH = 8,
    parameter int P_RATIO = 4
);
    logic [P_WIDTH-1:0]         in_data;
    logic                       in_vld;
    logic                       in_rdy;
    logic [P_WIDTH*P_RATIO-1:0] out_data;
    logic [P_RATIO-1:0]         out_keep;
    logic                       out_vld;
    logic                       out_rdy;

    modport slave (
        input  in_data, in_vld, out_rdy,
        output in_rdy, out_data, out_keep, out_vld
    );

    modport master (
        output in_data, in_vld, out_rdy,
        input  in_rdy, out_data, out_keep, out_vld
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Packs P_RATIO narrow FIFO read words (little-endian lanes) into one wide word.
// Optional idle flush of partial words: define FIFO_RD_PACKER_FLUSH_TIMEOUT_EN.
module fifo_rd_packer #(
    parameter int P_WIDTH   = 8,
    parameter int P_RATIO   = 4,
    parameter int P_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    fifo_rd_packer_if.slave bus
);
    localparam int IDX_W = $clog2(P_RATIO);
    localparam int OUT_W = P_WIDTH * P_RATIO;

    typedef enum logic [0:0] {ST_FILL, ST_OUT} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [OUT_W-1:0]   acc_reg, acc_next;
    logic [P_RATIO-1:0] keep_reg, keep_next;
    logic [P_RATIO-1:0] lane_we;
    logic               en_reg;
    logic               accept;
    logic               handshake;
    logic               clr_acc;

    // en_reg holds in_rdy low from reset until the first clock edge after release
    assign bus.in_rdy   = en_reg & ((state_reg == ST_FILL) | bus.out_rdy);
    assign bus.out_vld  = (state_reg == ST_OUT);
    assign bus.out_data = acc_reg;
    assign bus.out_keep = keep_reg;

    assign accept    = bus.in_vld & bus.in_rdy;
    assign handshake = (state_reg == ST_OUT) & bus.out_rdy;
    assign clr_acc   = accept & (idx_reg == '0);

    // A word starting at lane 0 wipes the stale lanes so partial words read zero
    generate
        for (genvar gi = 0; gi < P_RATIO; gi++) begin : g_lane
            assign lane_we[gi] = accept & (idx_reg == IDX_W'(gi));
            assign acc_next[gi*P_WIDTH +: P_WIDTH] =
                lane_we[gi] ? bus.in_data :
                clr_acc     ? '0 : acc_reg[gi*P_WIDTH +: P_WIDTH];
        end
    endgenerate

`ifdef FIFO_RD_PACKER_FLUSH_TIMEOUT_EN
    localparam int TMO_W = $clog2(P_TIMEOUT + 1);

    logic [TMO_W-1:0]   idle_reg, idle_next;
    logic [P_RATIO-1:0] flush_keep;

    generate
        for (genvar gi = 0; gi < P_RATIO; gi++) begin : g_keep
            assign flush_keep[gi] = (idx_reg > IDX_W'(gi));
        end
    endgenerate
`endif

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        keep_next  = keep_reg;
`ifdef FIFO_RD_PACKER_FLUSH_TIMEOUT_EN
        idle_next  = '0;
`endif
        case (state_reg)
            ST_FILL: begin
                if (accept) begin
                    if (idx_reg == IDX_W'(P_RATIO - 1)) begin
                        state_next = ST_OUT;
                        idx_next   = '0;
                        keep_next  = '1;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
`ifdef FIFO_RD_PACKER_FLUSH_TIMEOUT_EN
                else if (idx_reg != '0) begin
                    if (idle_reg == TMO_W'(P_TIMEOUT - 1)) begin
                        state_next = ST_OUT;
                        idx_next   = '0;
                        keep_next  = flush_keep;
                    end else begin
                        idle_next = idle_reg + TMO_W'(1);
                    end
                end
`endif
            end
            ST_OUT: begin
                if (handshake) begin
                    state_next = ST_FILL;
                    if (accept) begin
                        idx_next = IDX_W'(1);
                    end
                end
            end
            default: state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_FILL;
            idx_reg   <= '0;
            acc_reg   <= '0;
            keep_reg  <= '0;
            en_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            acc_reg   <= acc_next;
            keep_reg  <= keep_next;
            en_reg    <= 1'b1;
        end
    end

`ifdef FIFO_RD_PACKER_FLUSH_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_reg <= '0;
        end else begin
            idle_reg <= idle_next;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: reset, packing, backpressure, streaming, timeout, reset mid-word.
module tb_fifo_rd_packer;
    localparam int P_WIDTH   = 8;
    localparam int P_RATIO   = 4;
    localparam int P_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fifo_rd_packer_if #(.P_WIDTH(P_WIDTH), .P_RATIO(P_RATIO)) bus();

    fifo_rd_packer #(
        .P_WIDTH  (P_WIDTH),
        .P_RATIO  (P_RATIO),
        .P_TIMEOUT(P_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_vld = 1'b0; bus.in_data = '0; bus.out_rdy = 1'b0;
        tick(); tick();
        checks++;
        if (bus.in_rdy !== 1'b0 || bus.out_vld !== 1'b0) begin
            errors++; $display("FAIL reset_hold: in_rdy=%b out_vld=%b want 0 0", bus.in_rdy, bus.out_vld);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_release_rdy: in_rdy=%b want 1", bus.in_rdy);
        end
        // fill a word with out_rdy low, then reset asynchronously mid-cycle
        bus.in_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 8'(8'hC1 + i);
            tick();
        end
        bus.in_vld = 1'b0;
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== 32'hC4C3C2C1) begin
            errors++; $display("FAIL reset_prefill: out_vld=%b data=%h want 1 c4c3c2c1", bus.out_vld, bus.out_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.out_data !== 32'h0 || bus.out_keep !== 4'h0 || bus.in_rdy !== 1'b0) begin
            errors++; $display("FAIL reset_async: vld=%b data=%h keep=%b rdy=%b want 0 0 0 0",
                bus.out_vld, bus.out_data, bus.out_keep, bus.in_rdy);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.in_rdy !== 1'b1 || bus.out_vld !== 1'b0) begin
            errors++; $display("FAIL reset_rerelease: in_rdy=%b out_vld=%b want 1 0", bus.in_rdy, bus.out_vld);
        end
        $display("reset test done");
    endtask

    task automatic test_basic();
        logic [7:0] words [4];
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.out_rdy = 1'b1;
        bus.in_vld  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = words[i];
            #0;
            checks++;
            if (bus.in_rdy !== 1'b1 || bus.out_vld !== 1'b0) begin
                errors++; $display("FAIL basic_fill_%0d: in_rdy=%b out_vld=%b want 1 0", i, bus.in_rdy, bus.out_vld);
            end
            tick();
        end
        bus.in_vld = 1'b0;
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== 32'h44332211 || bus.out_keep !== 4'b1111) begin
            errors++; $display("FAIL basic_out: vld=%b data=%h keep=%b want 1 44332211 1111",
                bus.out_vld, bus.out_data, bus.out_keep);
        end
        $display("basic: out word %h keep %b", bus.out_data, bus.out_keep);
        tick();
        checks++;
        if (bus.out_vld !== 1'b0) begin
            errors++; $display("FAIL basic_one_cycle: out_vld=%b want 0", bus.out_vld);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] words [4];
        words = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.out_rdy = 1'b0;
        bus.in_vld  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = words[i];
            tick();
        end
        bus.in_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.in_rdy !== 1'b0 || bus.out_vld !== 1'b1 || bus.out_data !== 32'h44332211 ||
                bus.out_keep !== 4'b1111) begin
                errors++; $display("FAIL bp_hold_%0d: rdy=%b vld=%b data=%h keep=%b want 0 1 44332211 1111",
                    i, bus.in_rdy, bus.out_vld, bus.out_data, bus.out_keep);
            end
            tick();
        end
        bus.out_rdy = 1'b1;
        #1;
        checks++;
        if (bus.in_rdy !== 1'b1) begin
            errors++; $display("FAIL bp_rdy_follow: in_rdy=%b want 1", bus.in_rdy);
        end
        $display("backpressure: out word %h released", bus.out_data);
        tick();
        checks++;
        if (bus.out_vld !== 1'b0) begin
            errors++; $display("FAIL bp_release: out_vld=%b want 0", bus.out_vld);
        end
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 8'(8'h66 + 8'(i * 17));
            tick();
        end
        bus.in_vld = 1'b0;
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== 32'h88776655 || bus.out_keep !== 4'b1111) begin
            errors++; $display("FAIL bp_next_word: vld=%b data=%h keep=%b want 1 88776655 1111",
                bus.out_vld, bus.out_data, bus.out_keep);
        end
        $display("backpressure: out word %h keep %b", bus.out_data, bus.out_keep);
        tick();
    endtask

    task automatic test_back_to_back();
        int rdy_drops = 0;
        bus.out_rdy = 1'b1;
        bus.in_vld  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 8'(i + 1);
            #0;
            if (bus.in_rdy !== 1'b1) rdy_drops++;
            if (i == 4) begin
                checks++;
                if (bus.out_vld !== 1'b1 || bus.out_data !== 32'h04030201) begin
                    errors++; $display("FAIL stream_word0: vld=%b data=%h want 1 04030201", bus.out_vld, bus.out_data);
                end
                $display("stream: out word %h", bus.out_data);
            end
            tick();
        end
        bus.in_vld = 1'b0;
        checks++;
        if (rdy_drops != 0) begin
            errors++; $display("FAIL stream_rdy: in_rdy low on %0d cycles want 0", rdy_drops);
        end
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== 32'h08070605) begin
            errors++; $display("FAIL stream_word1: vld=%b data=%h want 1 08070605", bus.out_vld, bus.out_data);
        end
        $display("stream: out word %h", bus.out_data);
        tick();
    endtask

    task automatic test_timeout();
        int early = 0;
        bus.out_rdy = 1'b1;
        bus.in_vld  = 1'b1;
        bus.in_data = 8'hAA; tick();
        bus.in_data = 8'hBB; tick();
        bus.in_vld  = 1'b0;
`ifdef FIFO_RD_PACKER_FLUSH_TIMEOUT_EN
        for (int i = 0; i < P_TIMEOUT - 1; i++) begin
            tick();
            if (bus.out_vld !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL timeout_early: out_vld high on %0d cycles want 0", early);
        end
        tick();
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== 32'h0000BBAA || bus.out_keep !== 4'b0011) begin
            errors++; $display("FAIL timeout_flush: vld=%b data=%h keep=%b want 1 0000bbaa 0011",
                bus.out_vld, bus.out_data, bus.out_keep);
        end
        $display("timeout: flushed word %h keep %b", bus.out_data, bus.out_keep);
        tick();
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.out_vld !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL no_timeout: out_vld high on %0d cycles want 0", early);
        end
        // partial word must still be waiting at lane 2
        bus.in_vld = 1'b1;
        bus.in_data = 8'hCC; tick();
        bus.in_data = 8'hDD; tick();
        bus.in_vld = 1'b0;
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== 32'hDDCCBBAA || bus.out_keep !== 4'b1111) begin
            errors++; $display("FAIL no_timeout_resume: vld=%b data=%h keep=%b want 1 ddccbbaa 1111",
                bus.out_vld, bus.out_data, bus.out_keep);
        end
        $display("timeout disabled: out word %h", bus.out_data);
        tick();
`endif
    endtask

    task automatic test_reset_midword();
        int         n_out = 0;
        logic [31:0] seen = '0;
        bus.out_rdy = 1'b1;
        bus.in_vld  = 1'b1;
        bus.in_data = 8'hAA; tick();
        bus.in_data = 8'hBB; tick();
        bus.in_vld  = 1'b0;
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus.in_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_data = 8'(i + 1);
            if (i >= 4) bus.in_vld = 1'b0;
            tick();
            if (bus.out_vld === 1'b1) begin
                n_out++;
                seen = bus.out_data;
                $display("reset mid-word: out word %h", bus.out_data);
            end
        end
        checks++;
        if (n_out != 1) begin
            errors++; $display("FAIL midrst_count: outputs=%0d want 1", n_out);
        end
        checks++;
        if (seen !== 32'h04030201) begin
            errors++; $display("FAIL midrst_data: data=%h want 04030201", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_reset_midword();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
